// File: rtl/udp_pkt_buf.sv
// rtl/udp_pkt_buf.sv - FIFO to ping-pong RAM packetiser feeding the UDP send engine
//
// Ports:
//   clk          system clock
//   RST          synchronous reset, active-high
//   begin_work   CPU enable level (asynchronous, 2-flop synchronised)
//   cont_mode    1 = re-arm while enabled, 0 = one packet per enable rising edge
//   length       words per packet, sampled when leaving IDLE
//   udp_busy     UDP engine busy (asynchronous, 2-flop synchronised)
//   err_clr      clears the sticky err / len_err flags
//   fifo_data    FIFO read data
//   fifo_usedw   FIFO fill level
//   fifo_rden    FIFO read enable
//   ram_data     RAM write data (combinational copy of fifo_data)
//   ram_addr     RAM write address, MSB selects the bank being filled
//   ram_wren     RAM write enable
//   ping_pong    bank currently owned by the UDP engine
//   udp_start    start pulse to the UDP engine, START_W cycles wide
//   udp_len      length of the most recently committed bank
//   pkt_cnt      committed packet count, wraps
//   err          sticky: bank flipped while the engine was busy
//   len_err      sticky: requested length was 0 or larger than one bank

module udp_pkt_buf #(
    parameter int DW      = 16,
    parameter int AW      = 10,
    parameter int UW      = 13,
    parameter int RD_LAT  = 1,
    parameter int START_W = 10
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          begin_work,
    input  logic          cont_mode,
    input  logic [15:0]   length,
    input  logic          udp_busy,
    input  logic          err_clr,
    input  logic [DW-1:0] fifo_data,
    input  logic [UW-1:0] fifo_usedw,
    output logic          fifo_rden,
    output logic [DW-1:0] ram_data,
    output logic [AW:0]   ram_addr,
    output logic          ram_wren,
    output logic          ping_pong,
    output logic          udp_start,
    output logic [15:0]   udp_len,
    output logic [15:0]   pkt_cnt,
    output logic          err,
    output logic          len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_READ,
        S_DRAIN,
        S_FLIP,
        S_WAIT_BUSY,
        S_START
    } state_t;

    localparam int          SCW = $clog2(START_W + 1);
    localparam logic [31:0] LIM = 32'd1 << AW;

    state_t          state_q, state_d;
    logic            begin_m_q, begin_s_q, begin_p_q;
    logic            busy_m_q, busy_s_q;
    logic [15:0]     len_q, len_d;
    logic [AW:0]     rd_cnt_q, rd_cnt_d;
    logic [AW:0]     wr_cnt_q, wr_cnt_d;
    logic [AW:0]     addr_q, addr_d;
    logic            pp_q, pp_d;
    logic [15:0]     udp_len_q, udp_len_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic            err_q, err_d;
    logic            len_err_q, len_err_d;
    logic [SCW-1:0]  st_cnt_q, st_cnt_d;

    logic            rden;
    logic            wr_en;
    logic            start_req;
    logic            len_ok;
    logic            err_set;
    logic            len_err_set;

    // Synchronisers; begin_p_q holds the previous synchronised level for edge detection.
    always_ff @(posedge clk) begin
        if (RST) begin
            begin_m_q <= 1'b0;
            begin_s_q <= 1'b0;
            begin_p_q <= 1'b0;
            busy_m_q  <= 1'b0;
            busy_s_q  <= 1'b0;
        end else begin
            begin_m_q <= begin_work;
            begin_s_q <= begin_m_q;
            begin_p_q <= begin_s_q;
            busy_m_q  <= udp_busy;
            busy_s_q  <= busy_m_q;
        end
    end

    assign rden = (state_q == S_READ);

    // Write strobe is the read strobe delayed by the FIFO read latency.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign wr_en = rden;
        end else begin : g_latn
            logic [RD_LAT-1:0] pipe_q;
            logic [RD_LAT:0]   chain;
            assign chain = {pipe_q, rden};
            always_ff @(posedge clk) begin
                if (RST) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= chain[RD_LAT-1:0];
                end
            end
            assign wr_en = pipe_q[RD_LAT-1];
        end
    endgenerate

    assign start_req = cont_mode ? begin_s_q : (begin_s_q & ~begin_p_q);
    assign len_ok    = (length != 16'd0) && (32'(length) <= LIM);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        addr_d      = addr_q;
        pp_d        = pp_q;
        udp_len_d   = udp_len_q;
        pkt_cnt_d   = pkt_cnt_q;
        st_cnt_d    = st_cnt_q;
        err_set     = 1'b0;
        len_err_set = 1'b0;

        // Only the in-bank offset advances, so the bank bit can never wrap.
        if (wr_en) begin
            addr_d   = {addr_q[AW], addr_q[AW-1:0] + AW'(1)};
            wr_cnt_d = wr_cnt_q + (AW+1)'(1);
        end

        case (state_q)
            S_IDLE: begin
                addr_d   = {~pp_q, {AW{1'b0}}};
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                if (start_req) begin
                    if (!len_ok) begin
                        len_err_set = 1'b1;
                    end else begin
                        len_d   = length;
                        state_d = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (32'(fifo_usedw) >= 32'(len_q)) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_cnt_d = rd_cnt_q + (AW+1)'(1);
                if (16'(rd_cnt_q) == len_q - 16'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (16'(wr_cnt_q) == len_q) begin
                    state_d = S_FLIP;
                end
            end
            S_FLIP: begin
                pp_d      = ~pp_q;
                udp_len_d = len_q;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                err_set   = busy_s_q;
                state_d   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!busy_s_q) begin
                    st_cnt_d = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (st_cnt_q == SCW'(START_W - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    st_cnt_d = st_cnt_q + SCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A set in the same cycle as a clear wins.
        err_d     = err_set     | (err_q     & ~err_clr);
        len_err_d = len_err_set | (len_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            addr_q    <= '0;
            pp_q      <= 1'b0;
            udp_len_q <= '0;
            pkt_cnt_q <= '0;
            st_cnt_q  <= '0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            addr_q    <= addr_d;
            pp_q      <= pp_d;
            udp_len_q <= udp_len_d;
            pkt_cnt_q <= pkt_cnt_d;
            st_cnt_q  <= st_cnt_d;
            err_q     <= err_d;
            len_err_q <= len_err_d;
        end
    end

    assign fifo_rden = rden;
    assign ram_data  = fifo_data;
    assign ram_addr  = addr_q;
    assign ram_wren  = wr_en;
    assign ping_pong = pp_q;
    assign udp_start = (state_q == S_START);
    assign udp_len   = udp_len_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err       = err_q;
    assign len_err   = len_err_q;

endmodule
